axis_result_fifo: RTL

AXIS_RESULT_FIFO -- requirements
Module: axis_result_fifo

---
 rtl/axis_result_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axis_result_fifo.sv
// axis_result_fifo
//
// Buffers results from an upstream adder that has no backpressure and presents them on an
// AXI-Stream master port. The upstream side is a bare strobe (valid_i/data_i). When the FIFO
// is full and no read completes on the same edge, the strobe is dropped. Each drop sets a
// sticky overflow flag and increments a saturating drop counter.
//
// Ports
//   clk            input   clock, all state updates on the rising edge
//   reset          input   asynchronous, active-low reset
//   valid_i        input   upstream strobe, data_i valid this cycle
//   data_i         input   [WIDTH:0] upstream sum
//   m_axis_tvalid  output  AXI-Stream valid, high while the FIFO holds data
//   m_axis_tdata   output  [WIDTH:0] AXI-Stream data, the entry at the read pointer
//   m_axis_tready  input   AXI-Stream downstream ready
//   ready_o        output  advisory "not full" indication
//   count_o        output  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   overflow_o     output  sticky, at least one strobe dropped since reset
//   drop_cnt_o     output  [DROP_W-1:0] number of dropped strobes, saturating

module axis_result_fifo #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [WIDTH:0]             data_i,
    output logic                       m_axis_tvalid,
    output logic [WIDTH:0]             m_axis_tdata,
    input  logic                       m_axis_tready,
    output logic                       ready_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [DROP_W-1:0]          drop_cnt_o
);

    localparam int unsigned DW    = WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Storage and bookkeeping state
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic full;
    logic not_empty;
    logic rd_fire;
    logic wr_fire;
    logic drop;

    always_comb begin
        full      = (count_q == CNT_FULL);
        not_empty = (count_q != '0);
        // tvalid is derived purely from the occupancy register, so an empty FIFO never
        // reads, even when a strobe arrives on the same edge (no bypass path).
        rd_fire   = not_empty && m_axis_tready;
        // A full FIFO still accepts a strobe when a read frees the slot on the same edge.
        wr_fire   = valid_i && (!full || rd_fire);
        drop      = valid_i && full && !rd_fire;
    end

    // Next-state computation
    always_comb begin
        mem_d = mem_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // DEPTH is a power of two, so natural pointer overflow gives the DEPTH-1 -> 0 wrap.
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The data array is intentionally not reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs, all driven from registers only
    always_comb begin
        m_axis_tvalid = not_empty;
        m_axis_tdata  = mem_q[rd_ptr_q];
        ready_o       = (count_q < CNT_FULL);
        count_o       = count_q;
        overflow_o    = overflow_q;
        drop_cnt_o    = drop_cnt_q;
    end

endmodule
